// File: rtl/huffman_pkg.sv
// huffman_pkg: decoder word widths and the scheduler state encoding
package huffman_pkg;
  localparam int IN_WORD_WIDTH = 5;
  localparam int OUT_WORD_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr_i (wrapping) as one-hot and index
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] j;
  // walk from the farthest offset down so the nearest requester wins
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) idx_o = j;
    end
  end
  assign gnt_o = (|req_i) ? N'(1) << idx_o : '0;
endmodule

// File: rtl/huffman_stream_scheduler.sv
// huffman_stream_scheduler: per-packet round-robin sharing of one huffman_decoder, draining before regrant.
// Define HUFF_SCHED_WDOG_EN to add the drain watchdog (WDOG_CYCLES) and the sticky err_wdog flag.
module huffman_stream_scheduler
  import huffman_pkg::*;
#(
  parameter int N_STREAMS = 4
`ifdef HUFF_SCHED_WDOG_EN
  , parameter int WDOG_CYCLES = 256
`endif
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [N_STREAMS-1:0]                s_valid,
  output logic [N_STREAMS-1:0]                s_ready,
  input  logic [N_STREAMS*IN_WORD_WIDTH-1:0]  s_data,
  input  logic [N_STREAMS-1:0]                s_last,
  output logic                                d_valid,
  input  logic                                d_ready,
  output logic [IN_WORD_WIDTH-1:0]            d_data,
  input  logic                                d_idle,
  input  logic                                r_valid,
  output logic                                r_ready,
  input  logic [OUT_WORD_WIDTH-1:0]           r_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [OUT_WORD_WIDTH-1:0]           m_data,
  output logic [$clog2(N_STREAMS)-1:0]        m_id,
  output logic                                err_wdog
);
  localparam int IDW = $clog2(N_STREAMS);
  sched_state_t state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, arb_idx;
  logic [N_STREAMS-1:0] arb_gnt;
  logic [IN_WORD_WIDTH-1:0] s_words [N_STREAMS];
  logic drain_ok, wdog_fire;
  for (genvar g = 0; g < N_STREAMS; g++) begin : g_words
    assign s_words[g] = s_data[g*IN_WORD_WIDTH +: IN_WORD_WIDTH];
  end
  rr_arbiter #(.N(N_STREAMS)) u_arb (
    .req_i(s_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );
  assign drain_ok = d_idle && !r_valid;
`ifdef HUFF_SCHED_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);
  logic [WCW-1:0] wdog_q;
  logic err_q;
  assign wdog_fire = (state_q == DRAIN) && !drain_ok && (wdog_q == WCW'(WDOG_CYCLES - 1));
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog_q <= '0;
      err_q <= 1'b0;
    end else begin
      wdog_q <= (state_q == DRAIN && state_d == DRAIN) ? wdog_q + 1'b1 : '0;
      err_q <= err_q | wdog_fire;
    end
  end
  // raised in the expiring cycle itself, then held by err_q
  assign err_wdog = err_q | wdog_fire;
`else
  assign wdog_fire = 1'b0;
  assign err_wdog = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    s_ready = '0;
    d_valid = 1'b0;
    d_data = '0;
    case (state_q)
      IDLE: begin
        grant_d = (|arb_gnt) ? arb_idx : grant_q;
        state_d = (|arb_gnt) ? PASS : IDLE;
      end
      PASS: begin
        d_valid = s_valid[grant_q];
        d_data = s_words[grant_q];
        s_ready[grant_q] = d_ready;
        state_d = (s_valid[grant_q] && d_ready && s_last[grant_q]) ? DRAIN : PASS;
      end
      DRAIN: begin
        rr_ptr_d = (drain_ok || wdog_fire) ?
                   ((grant_q == IDW'(N_STREAMS - 1)) ? '0 : grant_q + 1'b1) : rr_ptr_q;
        state_d = (drain_ok || wdog_fire) ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  // return path is a pure passthrough, forced quiet while reset is asserted
  assign m_valid = rstn & r_valid;
  assign r_ready = rstn & m_ready;
  assign m_data = rstn ? r_data : '0;
  assign m_id = grant_q;
endmodule
